checker_trace_arbiter: RTL

- Shares the single serial character input of the CPU trace checker between two trace producers: register-write (GRF) and memory-write (MEM).
- Arbitrates round-robin between them and latches one record per grant.
- Serialises each record one ASCII character per cycle in the exact checker wire format.
  - GRF: "^TTTT@PPPPPPPP: $RRR <= DDDDDDDD#"
  - MEM: "^TTTT@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#"
- Sits between the CPU trace taps and the checker's char port.

---
 rtl/checker_trace_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/checker_trace_arbiter.sv
// checker_trace_arbiter
// Round-robin arbiter between the GRF and MEM trace producers. It latches one
// record per grant and streams it to the trace checker as ASCII, one character
// per cycle:
//   GRF: "^TTTT@PPPPPPPP: $RRR <= DDDDDDDD#"         (33 characters)
//   MEM: "^TTTT@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#"     (38 characters)
// A single position counter (0..37) walks the record. The FSM state names the
// field that is currently being emitted.
module checker_trace_arbiter #(
  parameter logic [7:0] IDLE_CHAR  = 8'h00,
  parameter logic       FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_valid,
  output logic        grf_ready,
  input  logic [15:0] grf_time,
  input  logic [31:0] grf_pc,
  input  logic [6:0]  grf_reg,
  input  logic [31:0] grf_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [15:0] mem_time,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC, S_SEP, S_DST, S_ASG, S_DAT, S_END
  } state_t;

  // Character positions that are common to both record kinds.
  localparam logic [5:0] P_HDR_LAST = 6'd4;
  localparam logic [5:0] P_PC       = 6'd5;
  localparam logic [5:0] P_PC_LAST  = 6'd13;
  localparam logic [5:0] P_SEP      = 6'd14;
  localparam logic [5:0] P_SEP_LAST = 6'd16;
  localparam logic [5:0] P_DST      = 6'd17;

  state_t      state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        ptr_q, ptr_d;     // 0: GRF wins a tie, 1: MEM wins a tie
  logic        sel_q, sel_d;     // kind of latched record, 0: GRF, 1: MEM

  logic [15:0] time_q;
  logic [31:0] pc_q;
  logic [31:0] dst_q;            // register number (GRF) or address (MEM)
  logic [31:0] data_q;

  logic        take_ok;
  logic        grant;
  logic [5:0]  dst_last, asg_base, asg_last, dat_base, dat_last;

  // Lowercase hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Nibble i of a 32-bit word, counting from the most significant nibble.
  function automatic logic [3:0] nib32(input logic [31:0] v, input logic [2:0] i);
    return 4'(v >> (5'd28 - {i, 2'b00}));
  endfunction

  // BCD digit i of the time field, most significant digit first.
  function automatic logic [3:0] bcd16(input logic [15:0] t, input logic [1:0] i);
    return 4'(t >> (4'd12 - {i, 2'b00}));
  endfunction

  // Decimal digit of a register number: 0 = hundreds, 1 = tens, 2 = units.
  function automatic logic [3:0] dec_digit(input logic [6:0] r, input logic [1:0] i);
    logic [3:0] d;
    case (i)
      2'd0:    d = 4'(r / 7'd100);
      2'd1:    d = 4'((r % 7'd100) / 7'd10);
      default: d = 4'(r % 7'd10);
    endcase
    return d;
  endfunction

  // The field boundaries after the separator depend on the record kind.
  assign dst_last = sel_q ? 6'd24 : 6'd19;
  assign asg_base = sel_q ? 6'd25 : 6'd20;
  assign asg_last = sel_q ? 6'd28 : 6'd23;
  assign dat_base = sel_q ? 6'd29 : 6'd24;
  assign dat_last = sel_q ? 6'd36 : 6'd31;

  // A grant is taken only when idle or while the closing '#' is on the wire.
  // Reset is included so that no ready is shown while reset is held.
  assign take_ok   = reset && ((state_q == S_IDLE) || (state_q == S_END));
  assign grf_ready = take_ok && grf_valid && (!mem_valid || !ptr_q);
  assign mem_ready = take_ok && mem_valid && (!grf_valid ||  ptr_q);
  assign grant     = grf_ready || mem_ready;

  // Control state: FSM, position counter, round-robin pointer, record kind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pos_q   <= 6'd0;
      ptr_q   <= FIRST_PRIO;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Record fields are captured from the granted producer on the grant edge.
  always_ff @(posedge clk) begin
    if (grf_ready) begin
      time_q <= grf_time;
      pc_q   <= grf_pc;
      dst_q  <= {25'd0, grf_reg};
      data_q <= grf_data;
    end else if (mem_ready) begin
      time_q <= mem_time;
      pc_q   <= mem_pc;
      dst_q  <= mem_addr;
      data_q <= mem_data;
    end
  end

  // Next state: step through the fields, and chain directly into a new record
  // from END when a grant is taken there.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q + 6'd1;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (grf_ready) begin
      ptr_d = 1'b1;
      sel_d = 1'b0;
    end else if (mem_ready) begin
      ptr_d = 1'b0;
      sel_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        pos_d = 6'd0;
        if (grant) state_d = S_HDR;
      end
      S_HDR: if (pos_q == P_HDR_LAST) state_d = S_PC;
      S_PC:  if (pos_q == P_PC_LAST)  state_d = S_SEP;
      S_SEP: if (pos_q == P_SEP_LAST) state_d = S_DST;
      S_DST: if (pos_q == dst_last)   state_d = S_ASG;
      S_ASG: if (pos_q == asg_last)   state_d = S_DAT;
      S_DAT: if (pos_q == dat_last)   state_d = S_END;
      S_END: begin
        pos_d   = 6'd0;
        state_d = grant ? S_HDR : S_IDLE;
      end
      default: begin
        pos_d   = 6'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output: the character for the current position of the latched record.
  always_comb begin
    char       = IDLE_CHAR;
    char_valid = 1'b1;
    busy       = 1'b1;
    case (state_q)
      S_HDR: begin
        if (pos_q == 6'd0) char = 8'h5e;  // '^'
        else char = 8'h30 + {4'h0, bcd16(time_q, 2'(pos_q - 6'd1))};
      end
      S_PC: begin
        if (pos_q == P_PC) char = 8'h40;  // '@'
        else char = hex_char(nib32(pc_q, 3'(pos_q - 6'd6)));
      end
      S_SEP: begin
        if (pos_q == P_SEP)           char = 8'h3a;  // ':'
        else if (pos_q == 6'd15)      char = 8'h20;  // ' '
        else                          char = sel_q ? 8'h2a : 8'h24;  // '*' / '$'
      end
      S_DST: begin
        if (sel_q) char = hex_char(nib32(dst_q, 3'(pos_q - P_DST)));
        else       char = 8'h30 + {4'h0, dec_digit(dst_q[6:0], 2'(pos_q - P_DST))};
      end
      S_ASG: begin
        case (2'(pos_q - asg_base))
          2'd1:    char = 8'h3c;  // '<'
          2'd2:    char = 8'h3d;  // '='
          default: char = 8'h20;  // ' '
        endcase
      end
      S_DAT: char = hex_char(nib32(data_q, 3'(pos_q - dat_base)));
      S_END: char = 8'h23;  // '#'
      default: begin
        char       = IDLE_CHAR;
        char_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

endmodule
